sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
//  Parametrised SHA-256 message padder for variable-length messages up to MAX_MSG_BITS.
//  - Latches a left-aligned message and its bit length.
//  - Builds the FIPS 180-4 padded stream: message bits, then '1', then zeros, then the 64-bit length.
//  - Streams the result one 512-bit block per valid/ready handshake to the hash core.
//  - Sits between the header/nonce assembly logic and the sha256 compression core.
// PARAMETERS
//  MAX_MSG_BITS  640  max message length in bits; must be a multiple of 8
//  MAX_BLOCKS    localparam = (MAX_MSG_BITS+64)/512 + 1; padded-buffer depth in blocks
//  LEN_W         localparam = $clog2(MAX_MSG_BITS+1)
//  IDX_W         localparam = $clog2(MAX_BLOCKS+1)
// PORTS
//  clk         in   1               clock
//  n_rst       in   1               reset, asynchronous, active-low
//  start       in   1               request; sampled only in IDLE
//  msg         in   MAX_MSG_BITS    message; first message bit at msg[MAX_MSG_BITS-1]
//  msg_len     in   LEN_W           message length in bits; bits [2:0] forced to 0
//  busy        out  1               high in every state except IDLE
//  blk_valid   out  1               blk_data holds a valid block
//  blk_ready   in   1               consumer accepts the block (handshake = valid & ready)
//  blk_data    out  512             current block; blk_data[511] is the first stream bit
//  blk_idx     out  IDX_W           index of the current block, starting at 0
//  blk_last    out  1               current block is the final block
//  num_blocks  out  IDX_W           N for the latched message; held until the next start
//  done        out  1               one-cycle pulse after the last block is accepted
//  err         out  1               only when SHA256_PAD_LENCHK_EN is defined
// BEHAVIOUR
//  Reset: state=IDLE, all buffers, outputs and counters = 0.
//  Length and block count:
//  - L = msg_len with bits [2:0] cleared.
//  - N = (L+64)/512 + 1, computed with integer division.
//  Padded stream, bit position p in [0, N*512):
//  - p < L: msg[MAX_MSG_BITS-1-p]
//  - p == L: 1
//  - p >= N*512-64: L as a 64-bit big-endian value
//  - otherwise: 0
//  FSM: IDLE -> LOAD -> EMIT -> DONE -> IDLE.
//  - IDLE: on start, latch msg and L, then go to LOAD.
//  - LOAD: one cycle; builds the MAX_BLOCKS*512-bit buffer, sets num_blocks, sets blk_idx=0.
//  - EMIT: blk_valid=1.
//    - blk_data, blk_idx and blk_last hold stable while blk_ready=0.
//    - On handshake with blk_last=0: shift the buffer left by 512 and increment blk_idx.
//    - On handshake with blk_last=1: go to DONE.
//  - DONE: done=1 for one cycle, then go to IDLE.
//  Latency: start seen in cycle t -> blk_valid=1 in cycle t+2. With blk_ready held high,
//  one block is emitted per cycle.
//  blk_last = (blk_idx == num_blocks-1).
//  start outside IDLE is ignored, including start coincident with done. No queueing.
//  An asynchronous reset mid-operation aborts the transfer; no partial done pulse.
//  The 64-bit length field is zero-extended from LEN_W.
// CONFIGURATION
//  SHA256_PAD_LENCHK_EN defined:
//  - start with msg_len > MAX_MSG_BITS is rejected; FSM stays in IDLE.
//  - err pulses high for 1 cycle; the previous num_blocks is kept.
//  SHA256_PAD_LENCHK_EN undefined:
//  - No err port.
//  - msg_len > MAX_MSG_BITS is clamped to MAX_MSG_BITS.
// STRUCTURE
//  Package sha256_pkg holds:
//  - SHA256_BLOCK_BITS=512 and SHA256_LEN_FIELD_BITS=64
//  - pad_state_t enum {IDLE, LOAD, EMIT, DONE}
//  - function sha256_num_blocks(L)
//  Sub-module sha256_pad_builder, purely combinational:
//  - Inputs: msg, L.
//  - Outputs: the padded MAX_BLOCKS*512-bit buffer and N.
//  - Registered by this FSM in LOAD.
// TESTING
//  1 L=640 (80-byte header) -> N=2.
//    - blk0 = msg[639:128].
//    - blk1 = {msg[127:0], 8'h80, 312'b0, 64'd640}; blk_last on blk1; done pulses once.
//  2 L=0 -> N=1; blk0 = {8'h80, 440'b0, 64'd0}; blk_last=1 at blk_idx=0.
//  3 L=440 -> N=1; blk0[71:64]=8'h80; blk0[63:0]=64'd440.
//  4 L=448 -> N=2.
//    - blk0 = {msg[639:192], 8'h80, 56'b0}.
//    - blk1 = {448'b0, 64'd448}.
//  5 L=640, blk_ready low for 5 cycles on each block -> blk_data and blk_idx stable.
//    - start pulsed during EMIT is ignored; exactly 2 handshakes occur.
//  6 Reset asserted mid-EMIT -> async IDLE, blk_valid=0, done=0.
//    - With SHA256_PAD_LENCHK_EN and msg_len=648: err pulses, busy stays 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 padding definitions: block/length-field sizes, padder FSM states,
// and the padded block-count helper.
// No ports (package).
package sha256_pkg;

    localparam int SHA256_BLOCK_BITS     = 512;
    localparam int SHA256_LEN_FIELD_BITS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } pad_state_t;

    // Blocks needed for L message bits, the '1' marker and the 64-bit length.
    function automatic int unsigned sha256_num_blocks(input int unsigned len_bits);
        return (len_bits + SHA256_LEN_FIELD_BITS) / SHA256_BLOCK_BITS + 1;
    endfunction

endpackage

// File: rtl/sha256_pad_builder.sv
// Purpose: combinational FIPS 180-4 padding of a left-aligned message into a multi-block buffer.
// Latency: zero (purely combinational); the parent FSM registers the result.
// Backpressure: none; the output simply follows msg and len.
// Ports: msg (left-aligned message), len (bit length, multiple of 8, <= MAX_MSG_BITS),
//        pad_buf (padded stream, first bit at MSB), num_blocks (N).
module sha256_pad_builder
    import sha256_pkg::*;
#(
    parameter  int MAX_MSG_BITS = 640,
    localparam int MAX_BLOCKS   = (MAX_MSG_BITS + SHA256_LEN_FIELD_BITS) / SHA256_BLOCK_BITS + 1,
    localparam int LEN_W        = $clog2(MAX_MSG_BITS + 1),
    localparam int IDX_W        = $clog2(MAX_BLOCKS + 1),
    localparam int BUF_W        = MAX_BLOCKS * SHA256_BLOCK_BITS
) (
    input  logic [MAX_MSG_BITS-1:0] msg,
    input  logic [LEN_W-1:0]        len,
    output logic [BUF_W-1:0]        pad_buf,
    output logic [IDX_W-1:0]        num_blocks
);

    int unsigned      n;
    logic [BUF_W-1:0] msg_ext;
    logic [BUF_W-1:0] msg_mask;
    logic [BUF_W-1:0] one_bit;
    logic [BUF_W-1:0] len_field;

    always_comb begin
        n         = sha256_num_blocks(32'(len));
        msg_ext   = {msg, {(BUF_W - MAX_MSG_BITS){1'b0}}};
        // Keep only the first len stream bits of the message.
        msg_mask  = ~({BUF_W{1'b1}} >> len);
        // Marker bit sits right after the last message bit.
        one_bit   = {1'b1, {(BUF_W - 1){1'b0}}} >> len;
        // Length lands in the final 64 bits of block N-1; unused trailing blocks stay zero.
        len_field = BUF_W'(64'(len)) << ((MAX_BLOCKS - n) * SHA256_BLOCK_BITS);
        pad_buf    = (msg_ext & msg_mask) | one_bit | len_field;
        num_blocks = IDX_W'(n);
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Purpose: latch a message, pad it for SHA-256 and stream it one 512-bit block per handshake.
// Latency: start in cycle t -> blk_valid in t+2; one block per cycle with blk_ready high.
// Backpressure: blk_data/blk_idx/blk_last hold while blk_ready is low; start ignored unless idle.
// Ports: clk, n_rst (async active-low), start/msg/msg_len request, busy, blk_valid/blk_ready/
//        blk_data/blk_idx/blk_last block stream, num_blocks, done pulse, err (length check build).
// Build option: SHA256_PAD_LENCHK_EN rejects over-long messages and adds err; otherwise clamps.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter  int MAX_MSG_BITS = 640,
    localparam int MAX_BLOCKS   = (MAX_MSG_BITS + SHA256_LEN_FIELD_BITS) / SHA256_BLOCK_BITS + 1,
    localparam int LEN_W        = $clog2(MAX_MSG_BITS + 1),
    localparam int IDX_W        = $clog2(MAX_BLOCKS + 1),
    localparam int BUF_W        = MAX_BLOCKS * SHA256_BLOCK_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic [MAX_MSG_BITS-1:0] msg,
    input  logic [LEN_W-1:0]        msg_len,
    output logic                    busy,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [511:0]            blk_data,
    output logic [IDX_W-1:0]        blk_idx,
    output logic                    blk_last,
    output logic [IDX_W-1:0]        num_blocks,
`ifdef SHA256_PAD_LENCHK_EN
    output logic                    err,
`endif
    output logic                    done
);

    pad_state_t              state, state_nxt;
    logic [MAX_MSG_BITS-1:0] msg_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        len_in;
    logic [BUF_W-1:0]        buf_q;
    logic [BUF_W-1:0]        pad_buf;
    logic [IDX_W-1:0]        pad_blocks;
    logic                    too_long;
    logic                    accept;
    logic                    hs;

    assign too_long = (msg_len > LEN_W'(MAX_MSG_BITS));
`ifdef SHA256_PAD_LENCHK_EN
    assign accept = start && !too_long;
    assign len_in = {msg_len[LEN_W-1:3], 3'b000};
`else
    assign accept = start;
    assign len_in = too_long ? LEN_W'(MAX_MSG_BITS) : {msg_len[LEN_W-1:3], 3'b000};
`endif

    sha256_pad_builder #(.MAX_MSG_BITS(MAX_MSG_BITS)) u_builder (
        .msg        (msg_q),
        .len        (len_q),
        .pad_buf    (pad_buf),
        .num_blocks (pad_blocks)
    );

    assign busy      = (state != IDLE);
    assign blk_valid = (state == EMIT);
    assign done      = (state == DONE);
    assign blk_data  = buf_q[BUF_W-1 -: 512];
    assign blk_last  = (blk_idx == num_blocks - IDX_W'(1));
    assign hs        = blk_valid && blk_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    state_nxt = EMIT;
            EMIT:    if (hs && blk_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            msg_q      <= '0;
            len_q      <= '0;
            buf_q      <= '0;
            num_blocks <= '0;
            blk_idx    <= '0;
        end else begin
            if (state == IDLE && accept) begin
                msg_q <= msg;
                len_q <= len_in;
            end
            if (state == LOAD) begin
                buf_q      <= pad_buf;
                num_blocks <= pad_blocks;
                blk_idx    <= '0;
            end
            if (hs && !blk_last) begin
                buf_q   <= buf_q << SHA256_BLOCK_BITS;
                blk_idx <= blk_idx + IDX_W'(1);
            end
        end
    end

`ifdef SHA256_PAD_LENCHK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) err <= 1'b0;
        else        err <= (state == IDLE) && start && too_long;
    end
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: reset, padding boundaries, backpressure, abort.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// Build option SHA256_PAD_LENCHK_EN switches the over-length step to the reject path.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         blk_ready = 1'b0;
    logic [639:0] msg = '0;
    logic [9:0]   msg_len = '0;
    logic         busy, blk_valid, blk_last, done;
    logic [511:0] blk_data;
    logic [1:0]   blk_idx, num_blocks;
`ifdef SHA256_PAD_LENCHK_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int nblk, done_cnt, hs0;
    logic [511:0] got [4];
    logic [1:0]   got_idx [4];
    logic         got_last [4];
    logic [639:0] m;
    logic [511:0] exp0, exp1, save0;
    logic         stable;

    sha256_msg_padder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .msg        (msg),
        .msg_len    (msg_len),
        .busy       (busy),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_idx    (blk_idx),
        .blk_last   (blk_last),
        .num_blocks (num_blocks),
`ifdef SHA256_PAD_LENCHK_EN
        .err        (err),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (blk_valid && blk_ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a request and check the two-cycle start-to-valid latency.
    task automatic send(input logic [639:0] mv, input logic [9:0] lv);
        @(negedge clk);
        msg = mv; msg_len = lv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_valid", 512'(blk_valid), 512'(0));
        chk("load_busy", 512'(busy), 512'(1));
        @(negedge clk);
        chk("emit_valid", 512'(blk_valid), 512'(1));
        chk("emit_idx0", 512'(blk_idx), 512'(0));
    endtask

    // Accept everything for a fixed window, recording each block and done pulses.
    task automatic drain();
        nblk = 0; done_cnt = 0; blk_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (done) done_cnt++;
            if (blk_valid && nblk < 4) begin
                got[nblk] = blk_data; got_idx[nblk] = blk_idx; got_last[nblk] = blk_last;
                nblk++;
            end
            @(negedge clk);
        end
        blk_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 80; i++) m[639 - 8*i -: 8] = 8'(i * 37 + 5);
        exp0 = m[639:128];
        exp1 = {m[127:0], 8'h80, 312'b0, 64'd640};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 512'(blk_valid), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_idx", 512'(blk_idx), 512'(0));
        chk("rst_nblk", 512'(num_blocks), 512'(0));
        chk("rst_data", blk_data, 512'(0));
        n_rst = 1'b1;

        // 1: 80-byte message, two blocks
        send(m, 10'd640);
        drain();
        chk("t1_count", 512'(nblk), 512'(2));
        chk("t1_blk0", got[0], exp0);
        chk("t1_blk1", got[1], exp1);
        chk("t1_idx1", 512'(got_idx[1]), 512'(1));
        chk("t1_last0", 512'(got_last[0]), 512'(0));
        chk("t1_last1", 512'(got_last[1]), 512'(1));
        chk("t1_done", 512'(done_cnt), 512'(1));
        chk("t1_nblocks", 512'(num_blocks), 512'(2));
        chk("t1_idle", 512'(busy), 512'(0));

        // 2: empty message
        send(m, 10'd0);
        drain();
        chk("t2_count", 512'(nblk), 512'(1));
        chk("t2_blk0", got[0], {8'h80, 440'b0, 64'd0});
        chk("t2_last0", 512'(got_last[0]), 512'(1));
        chk("t2_nblocks", 512'(num_blocks), 512'(1));

        // 3: largest length fitting one block
        send(m, 10'd440);
        drain();
        chk("t3_count", 512'(nblk), 512'(1));
        chk("t3_marker", 512'(got[0][71:64]), 512'(8'h80));
        chk("t3_len", 512'(got[0][63:0]), 512'(64'd440));
        chk("t3_msg", 512'(got[0][511:72]), 512'(m[639:200]));
        save0 = got[0];

        // 3b: low length bits are ignored (447 behaves as 440)
        send(m, 10'd447);
        drain();
        chk("t3b_blk0", got[0], save0);

        // 4: smallest length spilling into a second block
        send(m, 10'd448);
        drain();
        chk("t4_count", 512'(nblk), 512'(2));
        chk("t4_blk0", got[0], {m[639:192], 8'h80, 56'b0});
        chk("t4_blk1", got[1], {448'b0, 64'd448});
        chk("t4_last1", 512'(got_last[1]), 512'(1));

        // 5: backpressure on each block, start during EMIT ignored
        send(m, 10'd640);
        hs0 = hs_cnt;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            start = (c == 1); msg_len = 10'd0;
            @(negedge clk);
            if (blk_data !== exp0 || blk_idx !== 2'd0 || blk_valid !== 1'b1 || blk_last !== 1'b0)
                stable = 1'b0;
        end
        start = 1'b0;
        chk("t5_hold0", 512'(stable), 512'(1));
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (blk_data !== exp1 || blk_idx !== 2'd1 || blk_valid !== 1'b1 || blk_last !== 1'b1)
                stable = 1'b0;
        end
        chk("t5_hold1", 512'(stable), 512'(1));
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        chk("t5_done", 512'(done), 512'(1));
        repeat (6) @(negedge clk);
        chk("t5_handshakes", 512'(hs_cnt - hs0), 512'(2));
        chk("t5_nblocks", 512'(num_blocks), 512'(2));
        chk("t5_idle", 512'(busy), 512'(0));

        // Over-length request
`ifdef SHA256_PAD_LENCHK_EN
        @(negedge clk);
        msg = m; msg_len = 10'd648; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len_err", 512'(err), 512'(1));
        chk("len_busy", 512'(busy), 512'(0));
        @(negedge clk);
        chk("len_err_pulse", 512'(err), 512'(0));
        chk("len_busy2", 512'(busy), 512'(0));
        chk("len_nblocks", 512'(num_blocks), 512'(2));
`else
        send(m, 10'd1000);
        drain();
        chk("clamp_count", 512'(nblk), 512'(2));
        chk("clamp_blk1", got[1], exp1);
`endif

        // 6: asynchronous reset mid-EMIT
        send(m, 10'd640);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_valid", 512'(blk_valid), 512'(0));
        chk("t6_done", 512'(done), 512'(0));
        chk("t6_busy", 512'(busy), 512'(0));
        chk("t6_nblocks", 512'(num_blocks), 512'(0));
        @(negedge clk);
        n_rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || blk_valid) done_cnt++;
        end
        chk("t6_quiet", 512'(done_cnt), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
